acc_stream_64: RTL and testbench
================================

ACC_STREAM_64 -- requirements
Module: acc_stream_64

Interface
REQ-001 Parameter: CNT_W, 16, width of the beat counter reported with each result.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 in_valid  input  1  upstream beat valid.
REQ-005 in_ready  output  1  block can accept a beat.
REQ-006 in_data  input  64  operand to accumulate.
REQ-007 in_last  input  1  marks final beat of a frame; qualified by in_valid.
REQ-008 out_valid  output  1  frame result available.
REQ-009 out_ready  input  1  downstream accepts result.
REQ-010 out_sum  output  64  frame sum modulo 2^64.
REQ-011 out_ovf  output  1  sticky: any carry-out of bit 63 occurred during the frame.
REQ-012 out_count  output  CNT_W  number of beats in the frame, saturating.

Function
REQ-013 Beat transfer occurs on a rising edge where in_valid && in_ready; result transfer where out_valid && out_ready.
REQ-014 FSM states IDLE, ACC, HOLD; in_ready = 1 in IDLE and ACC, 0 in HOLD; out_valid = 1 only in HOLD.
REQ-015 The 64-bit addition is performed by one instance of the team's cla_64 (cin tied 0), with acc register and in_data as operands; cout is the carry-out.
REQ-016 IDLE + beat: acc <= in_data, ovf <= 0, count <= 1; next state HOLD if in_last else ACC.
REQ-017 ACC + beat: acc <= cla sum, ovf <= ovf | cout, count <= count+1 saturating at 2^CNT_W-1; next state HOLD if in_last else ACC.
REQ-018 IDLE/ACC without a beat (in_valid=0): acc, ovf, count, state unchanged.
REQ-019 HOLD: out_sum = acc, out_ovf = ovf, out_count = count, all stable while out_ready=0.
REQ-020 HOLD + out_ready: next state IDLE; no beat accepted in that cycle (in_ready=0).
REQ-021 Latency: last beat accepted at edge N -> out_valid high from cycle after edge N; minimum frame-to-frame throughput one frame per (beats+1) cycles.
REQ-022 Sum wrap-around: result is modulo 2^64; wrap sets out_ovf, never alters out_count.
REQ-023 Count saturation: once count = 2^CNT_W-1 further beats still accumulate, count holds.
REQ-024 in_data/in_last ignored whenever in_ready=0; in_last on a non-transferred cycle has no effect.
REQ-025 out_sum/out_ovf/out_count are don't-care outside HOLD but shall be driven from acc/ovf/count registers (no X).

Reset
REQ-026 While rst_n=0 at a rising edge: state <= IDLE, acc <= 0, ovf <= 0, count <= 0.
REQ-027 in_ready and out_valid shall be 0 while rst_n=0, irrespective of state.
REQ-028 Reset mid-frame (ACC or HOLD) discards partial/pending result; first beat after release starts a new frame from zero.
REQ-029 A beat presented in the same cycle rst_n=0 is not accepted.

Verification
REQ-030 Two beats 0xFFFF_FFFF_FFFF_FFFF, 0xFFFF_FFFF_FFFF_FFFF (last) -> out_sum 0xFFFF_FFFF_FFFF_FFFE, out_ovf 1, out_count 2.
REQ-031 Single beat 0x0000_0000_0000_1234 with in_last -> out_valid next cycle, out_sum 0x1234, out_ovf 0, out_count 1.
REQ-032 Beats 1..10 with in_valid bubbles between every beat -> out_sum 55, out_ovf 0, out_count 10.
REQ-033 Result with out_ready held 0 for 5 cycles -> out_valid, outputs stable, in_ready 0 throughout; IDLE after out_ready=1.
REQ-034 rst_n pulsed low after 3 beats of a frame, then frame {5, 7 last} -> out_sum 12, out_count 2, out_ovf 0.
REQ-035 CNT_W=2, frame of 5 beats of 1 -> out_sum 5, out_count 3.

Source files
------------

// File: rtl/acc_stream_64.sv
// Streaming 64-bit frame accumulator: sums beats of a frame and presents the
// sum, a sticky carry-out flag and a saturating beat count.

module cla_64 (
   input  logic [63:0] a,
   input  logic [63:0] b,
   input  logic        cin,
   output logic [63:0] sum,
   output logic        cout
);

   function automatic logic [3:0] carries4(input logic [3:0] g, input logic [3:0] p,
                                           input logic c0);
      logic [3:0] c;
      c[0] = c0;
      c[1] = g[0] | (p[0] & c0);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (&p[2:0] & c0);
      return c;
   endfunction

   function automatic logic gen4(input logic [3:0] g, input logic [3:0] p);
      return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   endfunction

   logic [63:0] g_bit, p_bit, c_bit;
   logic [15:0] g_grp, p_grp, c_grp;
   logic [3:0]  g_sup, p_sup, c_sup;

   // Three lookahead levels: bits -> 4-bit groups -> 16-bit supergroups -> word.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      g_grp = '0;
      p_grp = '0;
      c_grp = '0;
      g_sup = '0;
      p_sup = '0;
      c_bit = '0;
      g_bit = a & b;
      p_bit = a ^ b;
      for (int j = 0; j < 16; j++) begin
         g_grp[j] = gen4(g_bit[4*j +: 4], p_bit[4*j +: 4]);
         p_grp[j] = &p_bit[4*j +: 4];
      end
      for (int k = 0; k < 4; k++) begin
         g_sup[k] = gen4(g_grp[4*k +: 4], p_grp[4*k +: 4]);
         p_sup[k] = &p_grp[4*k +: 4];
      end
      c_sup = carries4(g_sup, p_sup, cin);
      cout  = gen4(g_sup, p_sup) | (&p_sup & cin);
      for (int k = 0; k < 4; k++)
         c_grp[4*k +: 4] = carries4(g_grp[4*k +: 4], p_grp[4*k +: 4], c_sup[k]);
      for (int j = 0; j < 16; j++)
         c_bit[4*j +: 4] = carries4(g_bit[4*j +: 4], p_bit[4*j +: 4], c_grp[j]);
      sum = p_bit ^ c_bit;
   end

endmodule

module acc_stream_64 #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [63:0]      in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [63:0]      out_sum,
   output logic             out_ovf,
   output logic [CNT_W-1:0] out_count
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ACC  = 2'd1;
   localparam logic [1:0] HOLD = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [63:0]      acc_q, acc_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [63:0]      cla_sum;
   logic             cla_cout;
   logic             beat;

   cla_64 u_cla (
      .a    (acc_q),
      .b    (in_data),
      .cin  (1'b0),
      .sum  (cla_sum),
      .cout (cla_cout)
   );

   // Handshakes are gated by rst_n so nothing transfers in a reset cycle.
   assign in_ready  = rst_n && (state_q != HOLD);
   assign out_valid = rst_n && (state_q == HOLD);
   assign beat      = in_valid && in_ready;

   assign out_sum   = acc_q;
   assign out_ovf   = ovf_q;
   assign out_count = count_q;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      count_d = count_q;
      case (state_q)
         IDLE: if (beat) begin
            acc_d   = in_data;
            ovf_d   = 1'b0;
            count_d = CNT_W'(1);
            state_d = in_last ? HOLD : ACC;
         end
         ACC: if (beat) begin
            acc_d   = cla_sum;
            ovf_d   = ovf_q | cla_cout;
            if (count_q != '1)
               count_d = count_q + CNT_W'(1);
            state_d = in_last ? HOLD : ACC;
         end
         HOLD: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_acc_stream_64.sv
// Self-checking bench for acc_stream_64: cycle table plus hand-written
// sequences for reset corners and count saturation (CNT_W=2 instance).

module tb_acc_stream_64;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_last, out_ready;
   logic [63:0] in_data;
   logic        in_ready, out_valid, out_ovf;
   logic [63:0] out_sum;
   logic [15:0] out_count;

   logic        in_valid2, in_last2, out_ready2;
   logic [63:0] in_data2;
   logic        in_ready2, out_valid2, out_ovf2;
   logic [63:0] out_sum2;
   logic [1:0]  out_count2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   acc_stream_64 #(.CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
      .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf),
      .out_count(out_count)
   );

   acc_stream_64 #(.CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
      .in_data(in_data2), .in_last(in_last2), .out_valid(out_valid2),
      .out_ready(out_ready2), .out_sum(out_sum2), .out_ovf(out_ovf2),
      .out_count(out_count2)
   );

   typedef struct {
      logic        v;
      logic [63:0] d;
      logic        last;
      logic        ordy;
      logic        e_ir;
      logic        e_ov;
      logic [63:0] e_sum;
      logic        e_ovf;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic v, input logic [63:0] d, input logic last, input logic ordy,
                      input logic e_ir, input logic e_ov, input logic [63:0] e_sum,
                      input logic e_ovf, input logic [15:0] e_cnt);
      vec_t e;
      e.v = v; e.d = d; e.last = last; e.ordy = ordy;
      e.e_ir = e_ir; e.e_ov = e_ov; e.e_sum = e_sum; e.e_ovf = e_ovf; e.e_cnt = e_cnt;
      tbl.push_back(e);
   endtask

   // Outputs are expected in ACC/IDLE (not valid) or HOLD (valid with result).
   task automatic add_acc(input logic v, input logic [63:0] d, input logic last);
      add(v, d, last, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 16'd0);
   endtask

   task automatic add_hold(input logic v, input logic [63:0] d, input logic last,
                           input logic [63:0] s, input logic o, input logic [15:0] c);
      add(v, d, last, 1'b0, 1'b0, 1'b1, s, o, c);
   endtask

   task automatic add_release();
      add(1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 16'd0);
   endtask

   // Inputs are applied 1 time unit after a rising edge; outputs checked 1 unit after the next.
   task automatic step(input logic v, input logic [63:0] d, input logic last, input logic ordy);
      in_valid = v; in_data = d; in_last = last; out_ready = ordy;
      @(posedge clk);
      #1;
   endtask

   task automatic check_hold(input string tag, input logic [63:0] s, input logic o,
                             input logic [15:0] c);
      check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_in_ready"},  64'(in_ready),  64'd0);
      check({tag, "_sum"},       out_sum, s);
      check({tag, "_ovf"},       64'(out_ovf), 64'(o));
      check({tag, "_count"},     64'(out_count), 64'(c));
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
      in_valid2 = 1'b0; in_data2 = '0; in_last2 = 1'b0; out_ready2 = 1'b0;

      // Single beat with last; result the cycle after.
      add_hold(1'b1, 64'h1234, 1'b1, 64'h1234, 1'b0, 16'd1);
      add_release();
      // Two all-ones beats wrap; in_data offered during HOLD is ignored.
      add_acc (1'b1, '1, 1'b0);
      add_hold(1'b1, '1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 16'd2);
      add_hold(1'b1, 64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 16'd2);
      add(1'b1, 64'd7, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 16'd0);
      // Backpressure for 5 cycles; ovf cleared by new frame.
      add_hold(1'b1, 64'd100, 1'b1, 64'd100, 1'b0, 16'd1);
      for (int i = 0; i < 5; i++) add_hold(1'b0, 64'd0, 1'b0, 64'd100, 1'b0, 16'd1);
      add_release();
      add_acc(1'b0, 64'd9, 1'b1);
      // Beats 1..10 with bubbles carrying a stray in_last.
      for (int k = 1; k <= 10; k++) begin
         if (k < 10) begin
            add_acc(1'b1, 64'(k), 1'b0);
            add_acc(1'b0, 64'hDEAD, 1'b1);
         end else begin
            add_hold(1'b1, 64'd10, 1'b1, 64'd55, 1'b0, 16'd10);
         end
      end
      add_release();
      // Sticky overflow survives a later carry-free beat.
      add_acc (1'b1, '1, 1'b0);
      add_acc (1'b1, 64'd1, 1'b0);
      add_hold(1'b1, 64'd0, 1'b1, 64'd0, 1'b1, 16'd3);
      add_release();
      // Carry across the 32-bit boundary, no carry-out.
      add_acc (1'b1, 64'h0000_0000_FFFF_FFFF, 1'b0);
      add_hold(1'b1, 64'd1, 1'b1, 64'h0000_0001_0000_0000, 1'b0, 16'd2);
      add_release();
      add_acc (1'b1, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0);
      add_hold(1'b1, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1, 64'h1E1E_1E1E_1E1E_1E1E, 1'b0, 16'd2);
      add_release();
      add_acc (1'b1, 64'h8000_0000_0000_0000, 1'b0);
      add_hold(1'b1, 64'h8000_0000_0000_0000, 1'b1, 64'h0, 1'b1, 16'd2);
      add_release();

      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready",  64'(in_ready),  64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_sum",       out_sum, 64'd0);
      check("rst_ovf",       64'(out_ovf), 64'd0);
      check("rst_count",     64'(out_count), 64'd0);
      rst_n = 1'b1;
      #1;
      check("idle_in_ready", 64'(in_ready), 64'd1);

      foreach (tbl[i]) begin
         step(tbl[i].v, tbl[i].d, tbl[i].last, tbl[i].ordy);
         check($sformatf("v%0d_in_ready", i),  64'(in_ready),  64'(tbl[i].e_ir));
         check($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
         if (tbl[i].e_ov) begin
            check($sformatf("v%0d_sum", i),   out_sum, tbl[i].e_sum);
            check($sformatf("v%0d_ovf", i),   64'(out_ovf), 64'(tbl[i].e_ovf));
            check($sformatf("v%0d_count", i), 64'(out_count), 64'(tbl[i].e_cnt));
         end
      end

      // Reset mid-frame with a beat offered during reset, then frame {5, 7}.
      step(1'b1, 64'd1, 1'b0, 1'b0);
      step(1'b1, 64'd2, 1'b0, 1'b0);
      step(1'b1, 64'd3, 1'b0, 1'b0);
      rst_n = 1'b0;
      in_data = 64'd99; in_last = 1'b1;
      #1;
      check("midrst_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      check("midrst_after_edge_in_ready", 64'(in_ready), 64'd0);
      rst_n = 1'b1;
      step(1'b0, 64'd0, 1'b0, 1'b0);
      check("midrst_idle_out_valid", 64'(out_valid), 64'd0);
      check("midrst_idle_in_ready",  64'(in_ready),  64'd1);
      step(1'b1, 64'd5, 1'b0, 1'b0);
      step(1'b1, 64'd7, 1'b1, 1'b0);
      check_hold("midrst", 64'd12, 1'b0, 16'd2);
      step(1'b0, 64'd0, 1'b0, 1'b1);
      check("midrst_release", 64'(out_valid), 64'd0);

      // Reset while holding a result discards it.
      step(1'b1, 64'd42, 1'b1, 1'b0);
      check_hold("holdrst_pre", 64'd42, 1'b0, 16'd1);
      rst_n = 1'b0;
      #1;
      check("holdrst_out_valid", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("holdrst_idle_out_valid", 64'(out_valid), 64'd0);
      check("holdrst_idle_in_ready",  64'(in_ready),  64'd1);
      step(1'b1, 64'd3, 1'b1, 1'b0);
      check_hold("holdrst_new", 64'd3, 1'b0, 16'd1);
      step(1'b0, 64'd0, 1'b0, 1'b1);

      // Narrow counter saturates at 3 while the sum keeps accumulating.
      for (int k = 1; k <= 5; k++) begin
         in_valid2 = 1'b1; in_data2 = 64'd1; in_last2 = (k == 5);
         @(posedge clk);
         #1;
      end
      in_valid2 = 1'b0; in_last2 = 1'b0;
      check("sat_out_valid", 64'(out_valid2), 64'd1);
      check("sat_sum",       out_sum2, 64'd5);
      check("sat_count",     64'(out_count2), 64'd3);
      check("sat_ovf",       64'(out_ovf2), 64'd0);
      out_ready2 = 1'b1;
      @(posedge clk);
      #1;
      out_ready2 = 1'b0;
      check("sat_release", 64'(out_valid2), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
